contactor_sequencer: RTL and testbench
======================================

# contactor_sequencer

Drives the pack precharge and main contactors from the battery fault FSM's 2-bit state and shutdown signal plus a host enable request. It sits between the fault FSM and the contactor drivers. It runs a timed precharge-then-close sequence and opens on faults. It latches sequencing errors, including welds, until the host clears them explicitly.

## Interface
Parameters:
- PRECHARGE_TIMEOUT, 2000: max cycles in PRECHARGE before error
- CLOSE_TIMEOUT, 100: max cycles for main_aux to assert after main_en
- OPEN_TIMEOUT, 100: max cycles for main_aux to deassert (OPENING), and weld-detect window in OPEN
- PRECHARGE_VDIFF, 200: max allowed pack_voltage − bus_voltage to close main (same units as inputs)

Ports (reset: asynchronous, active-high; clock: clk):
- clk  in  1  clock
- reset  in  1  async active-high reset
- fault_state  in  2  fault FSM state: 00 NORMAL, 01 WARNING, 10 FAULT, 11 SHUTDOWN
- shutdown_req  in  1  fault FSM shutdown signal
- enable_req  in  1  host request to close contactors (level)
- clear_req  in  1  host request to clear a latched error (level)
- pack_voltage  in  16  pack voltage, unsigned
- bus_voltage  in  16  DC-bus voltage, unsigned
- main_aux  in  1  main contactor auxiliary feedback, 1 = closed
- precharge_en  out  1  precharge contactor drive
- main_en  out  1  main contactor drive
- ready  out  1  main closed and verified
- error  out  1  sequencer in ERROR
- error_code  out  3  0 none, 1 precharge timeout, 2 main no-close, 3 main dropped, 4 weld/open fail, 5 shutdown
- seq_state  out  3  current state encoding

## Operation
States, with their outputs:
- OPEN=0: all drives 0.
- PRECHARGE=1: precharge_en=1.
- CLOSE_MAIN=2: precharge_en=1, main_en=1.
- CLOSED=3: main_en=1, ready=1.
- OPENING=4: all drives 0.
- ERROR=5: drives 0, error=1.

Abort condition: abort = shutdown_req | fault_state==FAULT | fault_state==SHUTDOWN | !enable_req.
- shut = shutdown_req | fault_state==SHUTDOWN.
- shut sets the sticky flag shut_seen in any state; only leaving ERROR clears it.

Transitions. Priority in each state is abort > progress > timeout.
- OPEN:
  - enable_req & fault_state==NORMAL & !shutdown_req & !main_aux → PRECHARGE.
  - WARNING blocks a new close but does not abort an active sequence.
  - main_aux high for OPEN_TIMEOUT consecutive cycles → ERROR, code 4.
- PRECHARGE:
  - abort → OPENING.
  - diff ≤ PRECHARGE_VDIFF → CLOSE_MAIN.
  - Timeout after PRECHARGE_TIMEOUT cycles → ERROR, code 1.
- CLOSE_MAIN:
  - abort → OPENING.
  - main_aux → CLOSED.
  - Timeout after CLOSE_TIMEOUT cycles → ERROR, code 2.
- CLOSED:
  - abort → OPENING.
  - !main_aux → ERROR, code 3.
- OPENING:
  - !main_aux: → ERROR code 5 if shut_seen, else → OPEN.
  - Timeout after OPEN_TIMEOUT cycles → ERROR, code 4.
- ERROR:
  - Exits to OPEN when clear_req & !shut & !main_aux all hold.
  - On exit, error_code→0 and shut_seen→0.

Arithmetic and timer rules:
- diff = pack_voltage − bus_voltage, saturating at 0 when bus_voltage ≥ pack_voltage. 16-bit unsigned, no wrap.
- A single timer counts cycles since state entry, starting at 0 in the first cycle.
- The timer clears on every state change. In OPEN it also clears whenever main_aux=0.
- The timer saturates and never wraps.
- Timeout fires when timer == LIMIT−1 and the progress condition is false, so the state lasts exactly LIMIT cycles.
- error_code is loaded on entry to ERROR and holds until ERROR exits.

## Timing
- All outputs decode from registered state and error_code only; there is no input-to-output combinational path.
- Input sampled true at edge N → new state and outputs valid after edge N. Example: enable_req seen at edge N gives precharge_en=1 in cycle N+1.
- Reset (async, including mid-sequence): state OPEN; precharge_en, main_en, ready, error = 0; error_code 0; seq_state 0; timer 0; shut_seen 0.
- precharge_en and main_en overlap for the whole CLOSE_MAIN state. main_en never asserts without a preceding PRECHARGE.
- clear_req held high while in ERROR exits in the first cycle the exit conditions hold. clear_req in other states is ignored.
- If abort and the progress condition are true in the same cycle, abort wins.

## Structure
- The shared package bms_pkg holds:
  - fault_state_t, the enum shared with the fault FSM;
  - seq_state_t, the 3-bit state enum;
  - err_code_t, the 3-bit code enum;
  - default timeout and threshold constants.
- The block is a single module with no sub-module. The timer and diff logic are inline.

## Test plan
- Normal close:
  - Stimulus: enable_req=1, NORMAL, pack=4000, bus ramps 0→3850 over 50 cycles; main_aux rises 5 cycles after main_en.
  - Required response: PRECHARGE → CLOSE_MAIN the cycle after bus ≥ 3800; ready=1 one cycle after main_aux.
- Precharge timeout:
  - Stimulus: bus held at 0.
  - Required response: ERROR with code 1 exactly 2000 cycles after PRECHARGE entry; drives 0.
- Shutdown while CLOSED:
  - Stimulus: shutdown_req pulsed 1 cycle; main_aux falls 10 cycles later.
  - Required response: OPENING next cycle, then ERROR code 5. clear_req only exits to OPEN once shutdown_req=0.
- Weld:
  - Stimulus: in OPENING, main_aux stuck at 1.
  - Required response: ERROR code 4 after 100 cycles.
  - Stimulus: in OPEN with main_aux=1 for 100 cycles.
  - Required response: ERROR code 4.
- WARNING and FAULT:
  - WARNING in OPEN blocks PRECHARGE.
  - WARNING in CLOSED keeps ready=1.
  - FAULT in CLOSED → OPENING, then OPEN (code 0) once main_aux=0.
- Reset mid-CLOSE_MAIN:
  - Stimulus: assert reset.
  - Required response: all outputs 0 immediately, before the next clk edge; state OPEN.

Source files
------------

// File: rtl/bms_pkg.sv
// Shared battery-management types: fault FSM state, contactor sequencer state,
// sequencer error codes and default timing/threshold constants.
package bms_pkg;

    typedef enum logic [1:0] {
        FS_NORMAL   = 2'b00,
        FS_WARNING  = 2'b01,
        FS_FAULT    = 2'b10,
        FS_SHUTDOWN = 2'b11
    } fault_state_t;

    typedef enum logic [2:0] {
        SEQ_OPEN       = 3'd0,
        SEQ_PRECHARGE  = 3'd1,
        SEQ_CLOSE_MAIN = 3'd2,
        SEQ_CLOSED     = 3'd3,
        SEQ_OPENING    = 3'd4,
        SEQ_ERROR      = 3'd5
    } seq_state_t;

    typedef enum logic [2:0] {
        ERR_NONE              = 3'd0,
        ERR_PRECHARGE_TIMEOUT = 3'd1,
        ERR_MAIN_NO_CLOSE     = 3'd2,
        ERR_MAIN_DROPPED      = 3'd3,
        ERR_WELD              = 3'd4,
        ERR_SHUTDOWN          = 3'd5
    } err_code_t;

    localparam int DEFAULT_PRECHARGE_TIMEOUT = 2000;
    localparam int DEFAULT_CLOSE_TIMEOUT     = 100;
    localparam int DEFAULT_OPEN_TIMEOUT      = 100;
    localparam int DEFAULT_PRECHARGE_VDIFF   = 200;
    localparam int SEQ_TIMER_W               = 16;

endpackage

// File: rtl/contactor_sequencer.sv
// Precharge-then-close contactor sequencer driven by the fault FSM and host enable;
// latches sequencing errors (timeouts, drops, welds, shutdowns) until the host clears them.
module contactor_sequencer
    import bms_pkg::*;
#(
    parameter int PRECHARGE_TIMEOUT = DEFAULT_PRECHARGE_TIMEOUT,
    parameter int CLOSE_TIMEOUT     = DEFAULT_CLOSE_TIMEOUT,
    parameter int OPEN_TIMEOUT      = DEFAULT_OPEN_TIMEOUT,
    parameter int PRECHARGE_VDIFF   = DEFAULT_PRECHARGE_VDIFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  fault_state,
    input  logic        shutdown_req,
    input  logic        enable_req,
    input  logic        clear_req,
    input  logic [15:0] pack_voltage,
    input  logic [15:0] bus_voltage,
    input  logic        main_aux,
    output logic        precharge_en,
    output logic        main_en,
    output logic        ready,
    output logic        error,
    output logic [2:0]  error_code,
    output logic [2:0]  seq_state
);

    localparam logic [SEQ_TIMER_W-1:0] PRE_LAST   = SEQ_TIMER_W'(PRECHARGE_TIMEOUT - 1);
    localparam logic [SEQ_TIMER_W-1:0] CLOSE_LAST = SEQ_TIMER_W'(CLOSE_TIMEOUT - 1);
    localparam logic [SEQ_TIMER_W-1:0] OPEN_LAST  = SEQ_TIMER_W'(OPEN_TIMEOUT - 1);
    localparam logic [15:0]            VDIFF_MAX  = 16'(PRECHARGE_VDIFF);

    function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
        return (b >= a) ? 16'd0 : a - b;
    endfunction

    function automatic logic [SEQ_TIMER_W-1:0] sat_inc(input logic [SEQ_TIMER_W-1:0] t);
        return (t == '1) ? t : t + 1'b1;
    endfunction

    fault_state_t            fs;
    seq_state_t              state, state_nxt;
    err_code_t               code, code_nxt;
    logic [SEQ_TIMER_W-1:0]  timer, timer_nxt;
    logic                    shut_seen, shut_seen_nxt;
    logic                    shut, abort;
    logic [15:0]             diff;

    assign fs    = fault_state_t'(fault_state);
    assign shut  = shutdown_req || (fs == FS_SHUTDOWN);
    assign abort = shut || (fs == FS_FAULT) || !enable_req;
    assign diff  = sat_sub(pack_voltage, bus_voltage);

    // Within each state: abort first, then progress, then timeout.
    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        case (state)
            SEQ_OPEN: begin
                if (enable_req && fs == FS_NORMAL && !shutdown_req && !main_aux) begin
                    state_nxt = SEQ_PRECHARGE;
                end else if (main_aux && timer == OPEN_LAST) begin
                    state_nxt = SEQ_ERROR;
                    code_nxt  = ERR_WELD;
                end
            end
            SEQ_PRECHARGE: begin
                if (abort) begin
                    state_nxt = SEQ_OPENING;
                end else if (diff <= VDIFF_MAX) begin
                    state_nxt = SEQ_CLOSE_MAIN;
                end else if (timer == PRE_LAST) begin
                    state_nxt = SEQ_ERROR;
                    code_nxt  = ERR_PRECHARGE_TIMEOUT;
                end
            end
            SEQ_CLOSE_MAIN: begin
                if (abort) begin
                    state_nxt = SEQ_OPENING;
                end else if (main_aux) begin
                    state_nxt = SEQ_CLOSED;
                end else if (timer == CLOSE_LAST) begin
                    state_nxt = SEQ_ERROR;
                    code_nxt  = ERR_MAIN_NO_CLOSE;
                end
            end
            SEQ_CLOSED: begin
                if (abort) begin
                    state_nxt = SEQ_OPENING;
                end else if (!main_aux) begin
                    state_nxt = SEQ_ERROR;
                    code_nxt  = ERR_MAIN_DROPPED;
                end
            end
            SEQ_OPENING: begin
                // A shutdown arriving in the same cycle the contactor opens still counts.
                if (!main_aux) begin
                    if (shut_seen || shut) begin
                        state_nxt = SEQ_ERROR;
                        code_nxt  = ERR_SHUTDOWN;
                    end else begin
                        state_nxt = SEQ_OPEN;
                    end
                end else if (timer == OPEN_LAST) begin
                    state_nxt = SEQ_ERROR;
                    code_nxt  = ERR_WELD;
                end
            end
            SEQ_ERROR: begin
                if (clear_req && !shut && !main_aux) begin
                    state_nxt = SEQ_OPEN;
                    code_nxt  = ERR_NONE;
                end
            end
            default: begin
                state_nxt = SEQ_OPEN;
                code_nxt  = ERR_NONE;
            end
        endcase
    end

    always_comb begin
        if (state_nxt != state) begin
            timer_nxt = '0;
        end else if (state == SEQ_OPEN && !main_aux) begin
            timer_nxt = '0;
        end else begin
            timer_nxt = sat_inc(timer);
        end
        if (state == SEQ_ERROR && state_nxt != SEQ_ERROR) begin
            shut_seen_nxt = 1'b0;
        end else begin
            shut_seen_nxt = shut_seen || shut;
        end
    end

    // Outputs are registered from the next state so they change with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= SEQ_OPEN;
            code         <= ERR_NONE;
            timer        <= '0;
            shut_seen    <= 1'b0;
            precharge_en <= 1'b0;
            main_en      <= 1'b0;
            ready        <= 1'b0;
            error        <= 1'b0;
            error_code   <= 3'd0;
            seq_state    <= 3'd0;
        end else begin
            state        <= state_nxt;
            code         <= code_nxt;
            timer        <= timer_nxt;
            shut_seen    <= shut_seen_nxt;
            precharge_en <= (state_nxt == SEQ_PRECHARGE) || (state_nxt == SEQ_CLOSE_MAIN);
            main_en      <= (state_nxt == SEQ_CLOSE_MAIN) || (state_nxt == SEQ_CLOSED);
            ready        <= (state_nxt == SEQ_CLOSED);
            error        <= (state_nxt == SEQ_ERROR);
            error_code   <= code_nxt;
            seq_state    <= state_nxt;
        end
    end

endmodule

// File: tb/tb_contactor_sequencer.sv
// Directed and randomized bench for contactor_sequencer with a cycle-level reference model.
module tb_contactor_sequencer;

    localparam int PT = 2000;
    localparam int CT = 100;
    localparam int OT = 100;
    localparam int VD = 200;

    localparam int S_OPEN = 0, S_PRE = 1, S_CM = 2, S_CLOSED = 3, S_OPENING = 4, S_ERR = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  fault_state;
    logic        shutdown_req, enable_req, clear_req, main_aux;
    logic [15:0] pack_voltage, bus_voltage;
    logic        precharge_en, main_en, ready, error;
    logic [2:0]  error_code, seq_state;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: state, latched code, cycles spent in state, aux-high run in OPEN.
    int m_state, m_code, m_age, m_run;
    bit m_ss;

    contactor_sequencer #(
        .PRECHARGE_TIMEOUT(PT), .CLOSE_TIMEOUT(CT), .OPEN_TIMEOUT(OT), .PRECHARGE_VDIFF(VD)
    ) dut (
        .clk(clk), .reset(reset), .fault_state(fault_state), .shutdown_req(shutdown_req),
        .enable_req(enable_req), .clear_req(clear_req), .pack_voltage(pack_voltage),
        .bus_voltage(bus_voltage), .main_aux(main_aux), .precharge_en(precharge_en),
        .main_en(main_en), .ready(ready), .error(error), .error_code(error_code),
        .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input int exp);
        vectors++;
        assert (got === 16'(exp)) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_state = S_OPEN; m_code = 0; m_age = 0; m_run = 0; m_ss = 0;
    endfunction

    function automatic void model_clock();
        bit shut, abort, closeable;
        int nxt, ncode;
        shut  = shutdown_req || (fault_state == 2'd3);
        abort = shut || (fault_state == 2'd2) || !enable_req;
        closeable = (int'(pack_voltage) - int'(bus_voltage)) <= VD;
        nxt = m_state; ncode = m_code;
        case (m_state)
            S_OPEN:
                if (enable_req && fault_state == 2'd0 && !shutdown_req && !main_aux) nxt = S_PRE;
                else if (main_aux && m_run + 1 == OT) begin nxt = S_ERR; ncode = 4; end
            S_PRE:
                if (abort) nxt = S_OPENING;
                else if (closeable) nxt = S_CM;
                else if (m_age + 1 == PT) begin nxt = S_ERR; ncode = 1; end
            S_CM:
                if (abort) nxt = S_OPENING;
                else if (main_aux) nxt = S_CLOSED;
                else if (m_age + 1 == CT) begin nxt = S_ERR; ncode = 2; end
            S_CLOSED:
                if (abort) nxt = S_OPENING;
                else if (!main_aux) begin nxt = S_ERR; ncode = 3; end
            S_OPENING:
                if (!main_aux) begin
                    if (m_ss || shut) begin nxt = S_ERR; ncode = 5; end
                    else nxt = S_OPEN;
                end else if (m_age + 1 == OT) begin nxt = S_ERR; ncode = 4; end
            default:
                if (clear_req && !shut && !main_aux) begin nxt = S_OPEN; ncode = 0; end
        endcase
        m_ss = (m_state == S_ERR && nxt != S_ERR) ? 1'b0 : (m_ss || shut);
        if (nxt != m_state) begin
            m_age = 0; m_run = 0;
        end else begin
            m_age++;
            m_run = main_aux ? m_run + 1 : 0;
        end
        m_state = nxt; m_code = ncode;
    endfunction

    task automatic chk_outputs();
        chk("seq_state", 16'(seq_state), m_state);
        chk("error_code", 16'(error_code), m_code);
        chk("precharge_en", 16'(precharge_en), int'(m_state == S_PRE || m_state == S_CM));
        chk("main_en", 16'(main_en), int'(m_state == S_CM || m_state == S_CLOSED));
        chk("ready", 16'(ready), int'(m_state == S_CLOSED));
        chk("error", 16'(error), int'(m_state == S_ERR));
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_clock();
            #1;
            chk_outputs();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 16'(seq_state), 0);
        chk({tag, "_code"}, 16'(error_code), 0);
        chk({tag, "_drives"}, 16'({precharge_en, main_en, ready, error}), 0);
    endtask

    task automatic do_close();
        fault_state = 2'd0; shutdown_req = 1'b0; clear_req = 1'b0;
        main_aux = 1'b0; bus_voltage = pack_voltage; enable_req = 1'b1;
        tick(2);
        chk("close_overlap", 16'({precharge_en, main_en}), 3);
        tick(2);
        main_aux = 1'b1;
        tick();
        chk("closed", 16'(seq_state), S_CLOSED);
    endtask

    initial begin
        reset = 1'b1; fault_state = 2'd0; shutdown_req = 1'b0; enable_req = 1'b0;
        clear_req = 1'b0; main_aux = 1'b0; pack_voltage = 16'd4000; bus_voltage = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        model_reset();
        tick(2);

        // Normal close with a ramping bus.
        enable_req = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            bus_voltage = 16'(i * 77);
            tick();
            if (i == 49) chk("still_precharge", 16'(seq_state), S_PRE);
        end
        chk("entered_close_main", 16'(seq_state), S_CM);
        tick(4);
        main_aux = 1'b1;
        tick();
        chk("ready_after_aux", 16'(ready), 1);

        // Open normally, then precharge timeout with bus held at 0.
        enable_req = 1'b0;
        tick();
        main_aux = 1'b0;
        tick();
        chk("back_to_open", 16'(seq_state), S_OPEN);
        bus_voltage = 16'd0; enable_req = 1'b1;
        tick();
        tick(PT - 1);
        chk("pre_last_cycle", 16'(seq_state), S_PRE);
        tick();
        chk("pre_timeout_code", 16'(error_code), 1);
        chk("pre_timeout_drives", 16'({precharge_en, main_en}), 0);
        enable_req = 1'b0; clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("cleared_code", 16'(error_code), 0);

        // Shutdown pulse while CLOSED.
        do_close();
        shutdown_req = 1'b1;
        tick();
        chk("shutdown_opening", 16'(seq_state), S_OPENING);
        shutdown_req = 1'b0;
        tick(9);
        main_aux = 1'b0;
        tick();
        chk("shutdown_code", 16'(error_code), 5);
        enable_req = 1'b0; shutdown_req = 1'b1; clear_req = 1'b1;
        tick(3);
        chk("clear_blocked_by_shut", 16'(seq_state), S_ERR);
        shutdown_req = 1'b0;
        tick();
        chk("clear_exits", 16'(seq_state), S_OPEN);
        clear_req = 1'b0;

        // Weld while OPENING, then weld in OPEN.
        do_close();
        enable_req = 1'b0;
        tick();
        tick(OT - 1);
        chk("opening_last_cycle", 16'(seq_state), S_OPENING);
        tick();
        chk("opening_weld_code", 16'(error_code), 4);
        clear_req = 1'b1;
        tick(2);
        chk("clear_blocked_by_aux", 16'(seq_state), S_ERR);
        main_aux = 1'b0;
        tick();
        clear_req = 1'b0;
        main_aux = 1'b1;
        tick(OT - 1);
        chk("open_weld_pending", 16'(seq_state), S_OPEN);
        tick();
        chk("open_weld_code", 16'(error_code), 4);
        main_aux = 1'b0; clear_req = 1'b1;
        tick();
        clear_req = 1'b0;

        // WARNING blocks a new close but not a closed pack; FAULT opens.
        fault_state = 2'd1; enable_req = 1'b1;
        tick(5);
        chk("warning_blocks", 16'(seq_state), S_OPEN);
        do_close();
        fault_state = 2'd1;
        tick(5);
        chk("warning_keeps_ready", 16'(ready), 1);
        fault_state = 2'd2;
        tick();
        chk("fault_opening", 16'(seq_state), S_OPENING);
        main_aux = 1'b0;
        tick();
        chk("fault_open_code", 16'(error_code), 0);
        fault_state = 2'd0; enable_req = 1'b0;
        tick();

        // Asynchronous reset in the middle of CLOSE_MAIN.
        enable_req = 1'b1; bus_voltage = pack_voltage;
        tick(2);
        chk("reset_setup", 16'(seq_state), S_CM);
        #1 reset = 1'b1;
        #1 chk_all_zero("async_reset");
        model_reset();
        enable_req = 1'b0;
        #1 reset = 1'b0;
        tick(2);

        // Randomized traffic with a loose contactor/bus plant.
        pack_voltage = 16'($urandom_range(3000, 4000));
        for (int i = 0; i < 3000; i++) begin
            fault_state  = ($urandom_range(0, 99) < 93) ? 2'd0 : 2'($urandom_range(0, 3));
            shutdown_req = ($urandom_range(0, 149) == 0);
            clear_req    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) enable_req = ~enable_req;
            if (main_aux != main_en && $urandom_range(0, 3) == 0) main_aux = main_en;
            if ($urandom_range(0, 199) == 0) main_aux = ~main_aux;
            if (precharge_en)
                bus_voltage = 16'((int'(bus_voltage) + int'($urandom_range(0, 300)) > int'(pack_voltage))
                              ? int'(pack_voltage) : int'(bus_voltage) + int'($urandom_range(0, 300)));
            else if (bus_voltage > 16'd50)
                bus_voltage = bus_voltage - 16'd50;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
